// File: rtl/mlpolar_ppm_encoder.sv
// Multilevel polar encoder and PPM slot mapper: ten component polar codes are built
// level by level from a serial info stream, then streamed out as N slot indices.
package pkg_mlpolar;
  localparam int N        = 256;
  localparam int LOG_N    = 8;
  localparam int K_LEVELS = 10;

  typedef logic [K_LEVELS-1:0][N-1:0] mask_rom_t;

  // Reed-Muller style frozen sets: a u index carries information only when its
  // Hamming weight reaches the level's threshold (lower levels are less reliable).
  function automatic int min_info_weight(input int lvl);
    case (lvl)
      0:       return 6;
      1, 2:    return 5;
      3, 4, 5: return 4;
      6, 7:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic mask_rom_t build_frozen_mask();
    mask_rom_t m;
    int        w;
    for (int lvl = 0; lvl < K_LEVELS; lvl++) begin
      for (int j = 0; j < N; j++) begin
        w = 0;
        for (int b = 0; b < LOG_N; b++) w += (j >> b) & 1;
        m[lvl][j] = (w < min_info_weight(lvl));
      end
    end
    return m;
  endfunction

  localparam mask_rom_t FROZEN_MASK = build_frozen_mask();
endpackage

module mlpolar_ppm_encoder
  import pkg_mlpolar::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                info_valid,
  input  logic                info_bit,
  output logic                info_ready,
  output logic                sym_valid,
  output logic [K_LEVELS-1:0] sym_slot,
  input  logic                sym_ready,
  output logic                block_done
);

  typedef enum logic [2:0] {IDLE, LOAD, XFORM, STORE, EMIT, DONE} state_t;

  state_t       state;
  logic [N-1:0] u_reg;
  logic [3:0]   lvl;
  logic [7:0]   idx;
  logic [2:0]   stg;
  logic [N-1:0] cw [K_LEVELS];

  logic         pos_frozen;
  logic         load_step;
  logic         sym_fire;
  logic [N-1:0] u_xform;

  // One butterfly stage of x = u * F^(x)8 in natural order: the lower index of every
  // pair at distance 2^s absorbs the upper one.
  function automatic logic [N-1:0] polar_stage(input logic [N-1:0] u, input logic [2:0] s);
    logic [N-1:0] v;
    v = u;
    for (int b = 0; b < LOG_N; b++) begin
      if (s == 3'(b)) begin
        for (int j = 0; j < N; j++) begin
          if (((j >> b) & 1) == 0) v[j] = u[j] ^ u[j + (1 << b)];
        end
      end
    end
    return v;
  endfunction

  assign pos_frozen = FROZEN_MASK[lvl][idx];
  assign info_ready = (state == LOAD) && !pos_frozen;
  assign load_step  = (state == LOAD) && (pos_frozen || info_valid);
  assign sym_valid  = (state == EMIT);
  assign sym_fire   = sym_valid && sym_ready;
  assign block_done = (state == DONE);
  assign u_xform    = polar_stage(u_reg, stg);

  // The slot label is the codeword column at idx, level i on bit i.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path through the block can leave a value unassigned (latch).
    sym_slot = '0;
    for (int i = 0; i < K_LEVELS; i++) sym_slot[i] = cw[i][idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      u_reg <= '0;
      lvl   <= '0;
      idx   <= '0;
      stg   <= '0;
      // NOTE: the codeword buffer is reset deliberately so an aborted block can never
      // leak old bits onto sym_slot; plain data memories normally stay unreset.
      cw    <= '{default: '0};
    end else begin
      // NOTE: sequential state is only ever written with non-blocking '<=' so every
      // register samples the pre-edge values of the others.
      case (state)
        IDLE: begin
          idx   <= '0;
          lvl   <= '0;
          stg   <= '0;
          u_reg <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (load_step) begin
            u_reg[idx] <= pos_frozen ? 1'b0 : info_bit;
            idx        <= idx + 8'd1;
            if (idx == 8'(N - 1)) begin
              stg   <= '0;
              state <= XFORM;
            end
          end
        end
        XFORM: begin
          u_reg <= u_xform;
          stg   <= stg + 3'd1;
          if (stg == 3'(LOG_N - 1)) state <= STORE;
        end
        STORE: begin
          cw[lvl] <= u_reg;
          idx     <= '0;
          if (lvl == 4'(K_LEVELS - 1)) begin
            state <= EMIT;
          end else begin
            lvl   <= lvl + 4'd1;
            state <= LOAD;
          end
        end
        EMIT: begin
          if (sym_fire) begin
            idx <= idx + 8'd1;
            if (idx == 8'(N - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mlpolar_ppm_encoder.md
# mlpolar_ppm_encoder

Multilevel polar encoder and PPM symbol mapper for the ML polar PPM link; the transmit-side counterpart of the multi-stage decoder. It accepts a serial stream of information bits and builds the ten component polar codewords, level 0 first, using the per-level frozen masks from `pkg_mlpolar`. It then emits N = 256 PPM slot indices. The 10-bit label of each slot is the column of codeword bits for that symbol, with level i on slot bit i.

## Interface
- `N`, 256 (from `pkg_mlpolar`): code length, which is also the number of PPM symbols per block.
- `K_LEVELS`, 10 (from `pkg_mlpolar`): number of bit levels, which is also the slot-index width.
- `FROZEN_MASK`, `pkg_mlpolar` ROM: per-level `[N-1:0]` mask. A 1 marks a frozen position; info bits per level = zeros in the mask.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `info_valid` in 1: `info_bit` is valid.
- `info_bit` in 1: information bit. Bits arrive in level order, ascending u index within each level.
- `info_ready` out 1: the encoder accepts `info_bit` this cycle.
- `sym_valid` out 1: `sym_slot` is valid.
- `sym_slot` out `K_LEVELS`: PPM slot index 0..1023.
- `sym_ready` in 1: downstream accepts the symbol.
- `block_done` out 1: one-cycle pulse after the last symbol of a block is accepted.

## Operation
- **States:** IDLE, LOAD, XFORM, STORE, EMIT, DONE.
- **Registers:** `u_reg[N-1:0]` holds working bits. `lvl` is 0..9. `idx` is 0..255. `stg` is 0..7. `cw[K_LEVELS][N]` is the codeword buffer.
- **IDLE:** Clears `idx`, `lvl` and `u_reg`, then goes to LOAD on the next cycle.
- **LOAD:** Fills `u_reg` one u position per step.
  - If `FROZEN_MASK[lvl][idx]` = 1: write 0 into `u_reg[idx]` and increment `idx`. This takes one cycle and does not consume input.
  - If the position is info: `info_ready` = 1. On `info_valid && info_ready`, write `u_reg[idx] <= info_bit` and increment `idx`. Otherwise hold.
  - When `idx` == N-1 completes, go to XFORM with `stg` = 0.
- **XFORM:** Applies the in-place polar transform x = u·F^⊗8 with F = [[1,0],[1,1]].
  - Natural order, no bit reversal, matching `polar_decoder_sc`.
  - Stage `stg`: for every j with bit `stg` = 0, `u_reg[j] <= u_reg[j] ^ u_reg[j + 2^stg]`. All 128 XORs happen in the same cycle.
  - One stage per cycle. After `stg` = 7, go to STORE.
- **STORE:** `cw[lvl] <= u_reg`.
  - If `lvl` = 9: go to EMIT with `idx` = 0.
  - Otherwise: increment `lvl`, clear `idx`, return to LOAD.
- **EMIT:**
  - `sym_valid` = 1.
  - `sym_slot` = {cw[9][idx], …, cw[0][idx]}, combinational from `idx`.
  - On `sym_valid && sym_ready`, increment `idx`. The handshake at `idx` = N-1 goes to DONE.
- **DONE:** `block_done` = 1 for one cycle, then IDLE.
- **Output qualification:** `info_ready` is high only in LOAD at info positions. `sym_valid` is high only in EMIT. No input is accepted during XFORM, STORE, EMIT or DONE.
- **Bits consumed per block:** sum over levels of the zeros in `FROZEN_MASK[lvl]` (K_INFO).

## Timing
- **Reset values:** `info_ready` = 0, `sym_valid` = 0, `sym_slot` = 0 (`cw` is cleared), `block_done` = 0. State = IDLE; all counters and `u_reg` = 0.
- **Reset mid-operation:** The partial block is discarded immediately (asynchronous). No stale codeword bits appear in the next block.
- **Per-level latency:** N LOAD cycles with no input stalls, plus 8 XFORM cycles, plus 1 STORE cycle = 265 cycles.
- **Block latency:** IDLE (1) + 10×265 + EMIT (≥256) + DONE (1) = 2908 cycles minimum.
- **First symbol:** `sym_valid` rises the cycle after STORE of level 9.
- **`info_valid` low at an info position:** `idx` holds and there is no timeout.
- **`sym_ready` low:** `sym_slot` and `idx` hold stable. No symbol is skipped or duplicated.
- **Last symbol:** `block_done` asserts in the cycle after the final accepted handshake. `sym_valid` = 0 in that cycle.
- **Frozen positions** advance even while `info_valid` = 1. `info_ready` = 0 there, so upstream holds the bit.

## Test plan
- **Reset:** Assert `rst_n` = 0 mid-LOAD. Required: all outputs 0. After release, `info_ready` rises at the first info position of level 0 and no earlier.
- **All-zero info:** Feed K_INFO zero bits. Required: 256 symbols, all with `sym_slot` = 10'h000. Exactly K_INFO `info_ready` handshakes. Exactly one `block_done`.
- **Single one:** All info bits 0 except u index 255 of level 9 (the final info bit). Required: all 256 symbols have `sym_slot` = 10'h200.
- **Single one at level 0, index p (first info index of level 0):** Required: bit 0 of symbol j = 1 iff (j & p) == j. Bits 9:1 = 0.
- **Backpressure and stalls:** Drop `sym_ready` for 5 cycles at symbol 17 and toggle `info_valid` randomly. Required: symbol sequence identical to the unstalled run, and `sym_slot` stable while stalled.
- **Reset mid-EMIT and loopback:**
  - Reset at symbol 100, then run a fresh random block. Required: correct fresh block.
  - Feed its symbols as `msd_controller` `obs_in` with bit 10 = 0. Required: the decoded info stream equals the input stream bit-for-bit.
